// File: rtl/mult_share_arb.sv
// Round-robin sharing of one combinational 32x32 multiplier between N_REQ requesters,
// with registers on both sides of the multiplier and one operation in flight at a time.
module mult_share_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*32-1:0] req_mplier,
  input  logic [N_REQ*32-1:0] req_mcand,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ID_W-1:0]     resp_id,
  output logic [63:0]         resp_product,
  output logic [31:0]         mul_mplier,
  output logic [31:0]         mul_mcand,
  input  logic [63:0]         mul_product
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] respId_q;
  logic [63:0]     respProduct_q;
  logic [31:0]     mulMplier_q;
  logic [31:0]     mulMcand_q;

  logic             grantFound;
  logic [ID_W-1:0]  grantIdx;
  logic [N_REQ-1:0] grantOneHot;
  logic [31:0]      selMplier;
  logic [31:0]      selMcand;

  // Two passes give the order ptr+1 .. N_REQ-1, then 0 .. ptr, which also skips
  // indices that do not exist when N_REQ is not a power of two.
  always_comb begin
    grantFound  = 1'b0;
    grantIdx    = '0;
    grantOneHot = '0;
    selMplier   = '0;
    selMcand    = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!grantFound && req_valid[j] && (ID_W'(j) > ptr_q)) begin
        grantFound     = 1'b1;
        grantIdx       = ID_W'(j);
        grantOneHot[j] = 1'b1;
        selMplier      = req_mplier[32*j +: 32];
        selMcand       = req_mcand[32*j +: 32];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!grantFound && req_valid[j] && (ID_W'(j) <= ptr_q)) begin
        grantFound     = 1'b1;
        grantIdx       = ID_W'(j);
        grantOneHot[j] = 1'b1;
        selMplier      = req_mplier[32*j +: 32];
        selMcand       = req_mcand[32*j +: 32];
      end
    end
  end

  assign req_ready    = (!rst && state_q == IDLE) ? grantOneHot : '0;
  assign resp_valid   = (state_q == DONE);
  assign resp_id      = respId_q;
  assign resp_product = respProduct_q;
  assign mul_mplier   = mulMplier_q;
  assign mul_mcand    = mulMcand_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= ID_W'(N_REQ - 1);
      respId_q      <= '0;
      respProduct_q <= '0;
      mulMplier_q   <= '0;
      mulMcand_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantFound) begin
            mulMplier_q <= selMplier;
            mulMcand_q  <= selMcand;
            respId_q    <= grantIdx;
            ptr_q       <= grantIdx;
            state_q     <= CALC;
          end
        end
        // The multiplier has had a full cycle to settle on registered operands.
        CALC: begin
          respProduct_q <= mul_product;
          state_q       <= DONE;
        end
        DONE: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: directed scenarios plus randomized traffic, predicted by a
// round-robin reference model and checked through a response scoreboard.
module tb_mult_share_arb;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_mplier;
  logic [N*32-1:0] req_mcand;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [63:0]     resp_product;
  logic [31:0]     mul_mplier;
  logic [31:0]     mul_mcand;
  logic [63:0]     mul_product;

  mult_share_arb #(.N_REQ(N), .ID_W(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mplier   (req_mplier),
    .req_mcand    (req_mcand),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .mul_mplier   (mul_mplier),
    .mul_mcand    (mul_mcand),
    .mul_product  (mul_product)
  );

  // Behavioural stand-in for the shared combinational multiplier.
  assign mul_product = {32'd0, mul_mplier} * {32'd0, mul_mcand};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  logic [N-1:0] pending;
  logic [31:0]  opA [N];
  logic [31:0]  opB [N];
  logic         respReadyDrive;
  int           modelPtr;
  bit           busy;
  int           age;
  bit           justReset;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid requester after the last granted one, wrapping round.
  function automatic int rrPick(input logic [N-1:0] v, input int p);
    logic [N-1:0] t;
    for (int k = 1; k <= N; k++) begin
      t = v >> ((p + k) % N);
      if (t[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] randOp();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One clock cycle: drive requester/consumer inputs, then check the cycle's outputs
  // against the model's view of whether the arbiter is busy and whom it should grant.
  task automatic applyStimulus(input bit doRst);
    int           g;
    bit           expRv;
    logic [N-1:0] expReady;
    @(negedge clk);
    rst       = doRst;
    req_valid = pending;
    for (int i = 0; i < N; i++) begin
      req_mplier[32*i +: 32] = opA[i];
      req_mcand[32*i +: 32]  = opB[i];
    end
    resp_ready = respReadyDrive;
    #1;
    if (justReset) begin
      checkOutput("reset resp_id", resp_id, 0);
      checkOutput("reset resp_product", resp_product, 0);
      checkOutput("reset mul_mplier", mul_mplier, 0);
      checkOutput("reset mul_mcand", mul_mcand, 0);
    end
    justReset = doRst;
    expRv = busy && (age >= 2);
    checkOutput("resp_valid", resp_valid, expRv);
    g = (doRst || busy) ? -1 : rrPick(pending, modelPtr);
    expReady = (g < 0) ? '0 : (N'(1) << g);
    checkOutput("req_ready", req_ready, expReady);
    if (doRst) begin
      busy     = 0;
      modelPtr = N - 1;
      expQ.delete();
    end else if (g >= 0) begin
      expQ.push_back('{g, opA[g], opB[g]});
      pending[g] = 1'b0;
      modelPtr   = g;
      busy       = 1;
      age        = 0;
    end else if (expRv && respReadyDrive) begin
      busy = 0;
    end
    age++;
  endtask

  task automatic randomRequests();
    for (int i = 0; i < N; i++) begin
      if (!pending[i] && $urandom_range(0, 2) == 0) begin
        pending[i] = 1'b1;
        opA[i]     = randOp();
        opB[i]     = randOp();
      end else if (pending[i] && $urandom_range(0, 24) == 0) begin
        pending[i] = 1'b0;
      end
    end
  endtask

  // Monitor: pops the scoreboard on each response handshake and checks that a
  // stalled response holds every output steady.
  initial begin : monitor
    exp_t           e;
    bit             held;
    logic [IDW-1:0] hId;
    logic [63:0]    hP;
    logic [31:0]    hA;
    logic [31:0]    hB;
    held = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 0;
      end else begin
        if (held) begin
          checkOutput("stall resp_id", resp_id, hId);
          checkOutput("stall resp_product", resp_product, hP);
          checkOutput("stall mul_mplier", mul_mplier, hA);
          checkOutput("stall mul_mcand", mul_mcand, hB);
        end
        if (resp_valid && resp_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected response: got id %0d, expected none at %0t", resp_id, $time);
          end else begin
            e = expQ.pop_front();
            checkOutput("resp_id", resp_id, e.id);
            checkOutput("resp_product", resp_product, 64'(e.a) * 64'(e.b));
            checkOutput("mul_mplier", mul_mplier, e.a);
            checkOutput("mul_mcand", mul_mcand, e.b);
          end
        end
        held = resp_valid && !resp_ready;
        hId  = resp_id;
        hP   = resp_product;
        hA   = mul_mplier;
        hB   = mul_mcand;
      end
    end
  end

  initial begin
    rst            = 1'b1;
    req_valid      = '0;
    req_mplier     = '0;
    req_mcand      = '0;
    resp_ready     = 1'b0;
    respReadyDrive = 1'b1;
    pending        = '0;
    for (int i = 0; i < N; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end
    modelPtr  = N - 1;
    busy      = 0;
    age       = 0;
    justReset = 0;

    // A request held during reset must not be granted.
    applyStimulus(1);
    pending[2] = 1'b1;
    opA[2]     = 32'd5;
    opB[2]     = 32'd6;
    applyStimulus(1);
    pending = '0;

    $display("[TB] single request");
    pending[1] = 1'b1;
    opA[1]     = 32'd7;
    opB[1]     = 32'd9;
    repeat (4) applyStimulus(0);

    $display("[TB] all four from reset");
    applyStimulus(1);
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b1;
      opA[i]     = 32'(i + 1);
      opB[i]     = 32'd10;
    end
    repeat (14) applyStimulus(0);

    $display("[TB] fairness");
    pending[2] = 1'b1;
    opA[2]     = 32'd3;
    opB[2]     = 32'd4;
    applyStimulus(0);
    pending[0] = 1'b1;
    opA[0]     = 32'd11;
    opB[0]     = 32'd12;
    pending[3] = 1'b1;
    opA[3]     = 32'd13;
    opB[3]     = 32'd14;
    repeat (10) applyStimulus(0);

    $display("[TB] extreme operands");
    pending[0] = 1'b1;
    opA[0]     = 32'hFFFF_FFFF;
    opB[0]     = 32'hFFFF_FFFF;
    pending[1] = 1'b1;
    opA[1]     = 32'd0;
    opB[1]     = 32'hFFFF_FFFF;
    pending[2] = 1'b1;
    opA[2]     = 32'h8000_0000;
    opB[2]     = 32'd2;
    repeat (12) applyStimulus(0);

    $display("[TB] backpressure");
    pending[1]     = 1'b1;
    opA[1]         = 32'hDEAD_BEEF;
    opB[1]         = 32'h1234_5678;
    respReadyDrive = 1'b0;
    repeat (3) applyStimulus(0);
    pending[2] = 1'b1;
    opA[2]     = 32'd100;
    opB[2]     = 32'd200;
    repeat (5) applyStimulus(0);
    respReadyDrive = 1'b1;
    repeat (6) applyStimulus(0);

    $display("[TB] reset in CALC");
    pending[3] = 1'b1;
    opA[3]     = 32'd77;
    opB[3]     = 32'd88;
    applyStimulus(0);
    applyStimulus(1);
    pending[0] = 1'b1;
    opA[0]     = 32'd21;
    opB[0]     = 32'd2;
    repeat (5) applyStimulus(0);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      randomRequests();
      respReadyDrive = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(0, 299) == 0);
    end

    pending        = '0;
    respReadyDrive = 1'b1;
    repeat (6) applyStimulus(0);
    checkOutput("scoreboard drained", 64'(expQ.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter/sequencer that shares one combinational 32x32 unsigned multiplier (`mult_comb_32`) between `N_REQ` requesters. Each requester presents an operand pair on a valid/ready handshake. The block grants one requester and registers its operands onto the multiplier inputs. It captures the 64-bit product one cycle later and returns it with the requester's ID on a valid/ready response channel. It sits between the client blocks and the single multiplier instance, so the multiplier's long combinational path is bounded by registers on both sides.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters; legal range 2..16.
- `ID_W`, 2: width of the requester index; must equal ceil(log2(`N_REQ`)).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `N_REQ`  bit i: requester i presents an operand pair.
- `req_ready`  out  `N_REQ`  bit i: requester i's operands are accepted this cycle; one-hot or zero.
- `req_mplier`  in  `N_REQ`*32  requester i's multiplier, at bits [32i+31:32i].
- `req_mcand`  in  `N_REQ`*32  requester i's multiplicand, at bits [32i+31:32i].
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  `ID_W`  index of the requester that owns `resp_product`.
- `resp_product`  out  64  unsigned product.
- `mul_mplier`  out  32  registered operand to the multiplier `mplier` input.
- `mul_mcand`  out  32  registered operand to the multiplier `mcand` input.
- `mul_product`  in  64  multiplier `product` output.

## Operation

- FSM states are IDLE, CALC and DONE. One operation is in flight at a time.
- **IDLE**
  - If any `req_valid` bit is set, grant requester g and assert `req_ready[g]` for this one cycle. `req_ready` is combinational from state, `req_valid` and the pointer.
  - At the clock edge, latch `req_mplier[g]` into `mul_mplier`, `req_mcand[g]` into `mul_mcand`, and g into `resp_id`.
  - Set the pointer to g and move to CALC.
  - If no `req_valid` bit is set, stay in IDLE.
- **CALC**
  - Operands are stable on `mul_*`; the multiplier settles.
  - At the clock edge, `resp_product <= mul_product`. Move to DONE.
- **DONE**
  - `resp_valid` = 1. `resp_id`, `resp_product` and `mul_*` are held.
  - When `resp_valid && resp_ready`, move to IDLE at the edge. Otherwise stay in DONE.
- **Round-robin arbitration**
  - Search order starts at pointer+1 and wraps modulo `N_REQ`, ending at the pointer itself.
  - The first requester in that order with `req_valid` set wins.
  - The pointer changes only on a grant.
  - The pointer resets to `N_REQ`-1, so requester 0 has top priority after reset.
- **Requester rules**
  - Once `req_valid` is raised, the requester holds valid and operands stable until `req_ready` is seen.
  - Dropping valid before the grant is permitted. The requester is then simply not considered.
- `req_ready` is all-zero in CALC and DONE and while `rst` = 1.
- **Arithmetic:** the product is a full-width unsigned 64-bit result. No truncation, no sign handling, no overflow.
- `N_REQ` that is not a power of two: the wrap skips non-existent indices.

## Timing

- **Reset values:** state IDLE; `req_ready` 0; `resp_valid` 0; `resp_id` 0; `resp_product` 0; `mul_mplier` 0; `mul_mcand` 0; pointer `N_REQ`-1.
- **Latency:** a grant in cycle t gives CALC in t+1 and `resp_valid` = 1 in t+2 with the product valid.
- **Throughput:** minimum initiation interval is 3 cycles when `resp_ready` is held at 1.
  - The next grant is earliest in the cycle after the response handshake.
  - Requests arriving in DONE wait.
- **Backpressure:** `resp_ready` = 0 holds DONE indefinitely. All outputs remain stable. No grants are issued.
- **Simultaneous events:** `req_valid` arriving in the same cycle as a response handshake is not granted in that cycle; it is granted in the following IDLE cycle.
- **Reset mid-operation** (CALC or DONE): the operation is discarded and no response is issued. All outputs return to their reset values in the cycle after `rst`. The pointer is reinitialised.
- `mul_product` is sampled only at the CALC→DONE edge. Its value in any other state is ignored.

## Test plan

- **Single request.** Requester 1 sends 7 and 9 at cycle 0.
  - `req_ready[1]` = 1 at cycle 0.
  - At cycle 2: `resp_valid` = 1, `resp_id` = 1, `resp_product` = 63.
- **All four valid from reset**, each `mplier` = i+1 and `mcand` = 10, `resp_ready` = 1.
  - Grants go to 0, 1, 2, 3, 3 cycles apart.
  - Products are 10, 20, 30, 40 with matching IDs.
- **Fairness.** After a grant to requester 2, requesters 0 and 3 are both valid.
  - Requester 3 is granted next, then requester 0.
- **Extreme operands.** 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE00000001.
  - 0 × 0xFFFFFFFF gives 0.
  - 0x80000000 × 2 gives 0x0000000100000000.
- **Backpressure.** Hold `resp_ready` = 0 for 5 cycles in DONE while requester 2 is valid.
  - Outputs stay stable and `req_ready` stays 0.
  - After the handshake, requester 2 is granted in the next cycle.
- **Reset in CALC.** Assert `rst` in CALC.
  - No `resp_valid` is issued.
  - All outputs are at reset values after one cycle.
  - The next request from requester 0 completes normally.
